// File: rtl/sipo_rx_ctrl.sv
// Receive sequencer for the FIFO_A sipo: frames start/data/stop bits, drives sipo mode, buffers one word.
// Optional even-parity framing is enabled by defining PARITY_SUPPORT_EN.
module sipo_rx_ctrl #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ser_in,
    output logic              sipo_mod,
    input  logic [DATA_W-1:0] sipo_data,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              frame_err,
    output logic              parity_err,
    output logic              overrun,
    input  logic              err_clr,
    output logic              busy
);

`ifdef PARITY_SUPPORT_EN
    typedef enum logic [2:0] {IDLE, SHIFT, PARITY, STOP, CAPTURE, WAIT_HI} state_t;
`else
    typedef enum logic [2:0] {IDLE, SHIFT, STOP, CAPTURE, WAIT_HI} state_t;
`endif

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             mod_d, frame_err_d, busy_d, capture;

`ifdef PARITY_SUPPORT_EN
    logic par_acc, par_acc_d, par_bad, par_bad_d, parity_err_d;
`endif

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        mod_d       = 1'b1;
        frame_err_d = 1'b0;
        capture     = 1'b0;
`ifdef PARITY_SUPPORT_EN
        par_acc_d    = par_acc;
        par_bad_d    = par_bad;
        parity_err_d = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!ser_in) begin
                    state_d = SHIFT;
                    mod_d   = 1'b0;
                    cnt_d   = '0;
`ifdef PARITY_SUPPORT_EN
                    par_acc_d = 1'b0;
`endif
                end
            end
            SHIFT: begin
                mod_d = 1'b0;
                cnt_d = cnt + 1'b1;
`ifdef PARITY_SUPPORT_EN
                par_acc_d = par_acc ^ ser_in;
`endif
                // The sipo shifts on this edge for the last time; hold from here on.
                if (cnt == LAST_BIT) begin
                    mod_d = 1'b1;
`ifdef PARITY_SUPPORT_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef PARITY_SUPPORT_EN
            PARITY: begin
                par_bad_d    = par_acc ^ ser_in;
                parity_err_d = par_acc ^ ser_in;
                state_d      = STOP;
            end
`endif
            STOP: begin
                if (!ser_in) begin
                    frame_err_d = 1'b1;
                    state_d     = WAIT_HI;
                end else begin
`ifdef PARITY_SUPPORT_EN
                    state_d = par_bad ? IDLE : CAPTURE;
`else
                    state_d = CAPTURE;
`endif
                end
            end
            CAPTURE: begin
                capture = 1'b1;
                // A low line right after the stop bit is the next frame's start bit.
                if (!ser_in) begin
                    state_d = SHIFT;
                    mod_d   = 1'b0;
                    cnt_d   = '0;
`ifdef PARITY_SUPPORT_EN
                    par_acc_d = 1'b0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_HI: begin
                if (ser_in) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            sipo_mod  <= 1'b1;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            sipo_mod  <= mod_d;
            frame_err <= frame_err_d;
            busy      <= busy_d;
        end
    end

`ifdef PARITY_SUPPORT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_acc    <= 1'b0;
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            par_acc    <= par_acc_d;
            par_bad    <= par_bad_d;
            parity_err <= parity_err_d;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    // Output buffer: a capture into a full, unconsumed buffer is dropped and flagged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_data  <= '0;
            m_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (capture) begin
                if (!m_valid || m_ready) begin
                    m_data  <= sipo_data;
                    m_valid <= 1'b1;
                end
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end

            if (capture && m_valid && !m_ready) overrun <= 1'b1;
            else if (err_clr)                   overrun <= 1'b0;
        end
    end

endmodule

// File: doc/sipo_rx_ctrl.md
Name: sipo_rx_ctrl

Overview:
- Sequencing controller for the 8-bit serial-in/parallel-out shift register (sipo) in the FIFO_A receive path.
- Watches the serial line, frames start/data/stop bits at one bit per clk, and drives the sipo mode input: hold (mod=1) or shift (mod=0).
- Captures the parallel word into a one-entry output register and offers it downstream with a valid/ready handshake; reports framing and overrun errors.

Parameters:
DATA_W, 8, data bits per frame; must equal the sipo width.
CNT_W, 4, bit-counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous, active-low reset.
ser_in  input  1  serial line; same net as sipo se_in; idle level 1.
sipo_mod  output  1  to sipo mod; 0 = shift, 1 = hold and transfer temp to pa_out.
sipo_data  input  DATA_W  from sipo pa_out.
m_data  output  DATA_W  captured word, LSB = first data bit.
m_valid  output  1  m_data holds an unconsumed word.
m_ready  input  1  downstream accepts m_data when m_valid and m_ready are both 1.
frame_err  output  1  one-cycle pulse on bad stop bit.
parity_err  output  1  one-cycle pulse on parity mismatch; constant 0 without PARITY_EN.
overrun  output  1  sticky; set when a word is dropped.
err_clr  input  1  synchronous clear of overrun.
busy  output  1  1 whenever state is not IDLE.

Behaviour:
- Reset values: state=IDLE, sipo_mod=1, m_data=0, m_valid=0, frame_err=0, parity_err=0, overrun=0, busy=0, bit counter=0.
- Reset mid-frame aborts the frame; no partial word is ever presented.
- All outputs are registered.
- Frame timing: start bit (0) is sampled at edge t; data bits d0..d(DATA_W-1) at edges t+1..t+DATA_W; stop bit (1) at edge t+DATA_W+1.
- IDLE: sipo_mod=1. When ser_in==0 is sampled, go to SHIFT, sipo_mod<=0, counter<=0.
- SHIFT: sipo_mod=0 for exactly DATA_W clk cycles, so the sipo shifts on edges t+1..t+DATA_W. The counter increments each edge. On the edge the counter reaches DATA_W-1, sipo_mod<=1 and go to STOP.
- STOP (edge t+DATA_W+1): the sipo transfers temp to pa_out on this same edge.
  - ser_in==1: go to CAPTURE.
  - ser_in==0: frame_err pulse, word discarded, go to WAIT_HI.
- CAPTURE (edge t+DATA_W+2): load sipo_data into m_data and set m_valid.
  - If ser_in==0 at this edge, it is a new start bit: go directly to SHIFT. This supports back-to-back frames with no idle gap.
  - Otherwise go to IDLE.
- WAIT_HI: sipo_mod=1; stay until ser_in==1 is sampled, then go to IDLE. A held-low line is never taken as a start bit.
- Handshake:
  - m_valid clears on an edge with m_ready=1 unless a capture occurs on the same edge.
  - m_data must be stable while m_valid=1 and m_ready=0.
- Capture with m_valid=1:
  - m_ready=1 on the same edge: the old word is consumed, the new word is loaded, m_valid stays 1, no overrun.
  - m_ready=0: the new word is dropped, the old word is retained, overrun<=1.
- overrun clears only via err_clr. If err_clr and a new overrun coincide, overrun stays set.
- Latency: start-bit edge to m_valid high = DATA_W+2 edges (10 for DATA_W=8).

Optional Feature:
- PARITY_SUPPORT_EN defined:
  - An even-parity bit follows the data bits. A PARITY state at edge t+DATA_W+1 samples it; STOP moves to t+DATA_W+2 and CAPTURE to t+DATA_W+3.
  - The controller XOR-accumulates ser_in during SHIFT. On mismatch it pulses parity_err and drops the word; the frame still ends through STOP (frame_err is checked as well).
  - sipo_mod timing is unchanged: 0 for exactly DATA_W cycles.
- Not defined: no PARITY state, parity_err tied 0, frame = 1+DATA_W+1 bits.

Test Plan:
- Single frame: ser_in = start 0, bits 1,0,1,0,0,1,0,1, stop 1, m_ready=1 → sipo_mod low for exactly 8 cycles; m_data=8'hA5 with m_valid high 10 edges after the start edge for one cycle; no error pulses.
- Back-to-back: 8'h3C frame immediately followed by a start bit for 8'hC3, m_ready=1 → both words delivered in order; no IDLE cycle between frames; busy stays 1.
- Bad stop: 8'hFF frame with stop=0, line then held low 5 cycles → one frame_err pulse; no m_valid; sipo_mod stays 1 until ser_in returns to 1; next valid 8'h01 frame received correctly.
- Overrun: two frames 8'h11 then 8'h22 with m_ready=0 → m_data stays 8'h11 and overrun=1; then err_clr=1 → overrun=0. Repeat with m_ready=1 pulsed on the second capture edge → m_data=8'h22, overrun=0.
- Reset mid-frame: rst low after the 4th data bit → all outputs at reset values immediately; a fresh 8'h5A frame after release is received correctly.
- PARITY_SUPPORT_EN: 8'h07 with parity bit 1 → m_data=8'h07. Repeat with parity bit 0 → parity_err pulse and no m_valid.
